// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard receiver with a scancode FIFO and a small register interface.
// The interface exposes DATA (pop), STATUS (flags and count) and CTRL (irq enable, flush).
module ps2_kbd_ctrl #(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        sel,
  input  logic [3:0]  addr,
  input  logic [3:0]  wenable,
  input  logic [31:0] wdata,
  input  logic        rd_en,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} rx_state_e;

  // Synchronizers, plus one extra ps2_clk stage for edge detection
  logic [1:0] kclk_sync_q, kdat_sync_q;
  logic       kclk_prev_q;

  rx_state_e      state_q, state_d;
  logic [7:0]     shift_q, shift_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic           parity_q, parity_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           rx_push, rx_perr, rx_ferr;

  logic [7:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           ovr_q, ovr_d, ferr_q, ferr_d, perr_q, perr_d;
  logic           irq_en_q, irq_en_d, irq_q, irq_d;
  logic [31:0]    rdata_q, rdata_d;

  logic fall, din, wr, rd, empty, full, pop, flush, push_acc, ovr_set, clr;
  logic unused_wdata;

  assign fall         = kclk_prev_q & ~kclk_sync_q[1];
  assign din          = kdat_sync_q[1];
  assign unused_wdata = ^wdata[31:5];

  // Input synchronizers; reset to the idle-high line level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kclk_sync_q <= 2'b11;
      kdat_sync_q <= 2'b11;
      kclk_prev_q <= 1'b1;
    end else begin
      kclk_sync_q <= {kclk_sync_q[0], ps2_clk};
      kdat_sync_q <= {kdat_sync_q[0], ps2_data};
      kclk_prev_q <= kclk_sync_q[1];
    end
  end

  // Frame receiver next state, including the inter-edge timeout abort
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    rx_push   = 1'b0;
    rx_perr   = 1'b0;
    rx_ferr   = 1'b0;
    case (state_q)
      StIdle: if (fall && !din) begin
        state_d   = StData;
        bit_cnt_d = '0;
      end
      StData: if (fall) begin
        shift_d   = {din, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) state_d = StParity;
      end
      StParity: if (fall) begin
        parity_d = din;
        state_d  = StStop;
      end
      StStop: if (fall) begin
        state_d = StIdle;
        if (!din)                       rx_ferr = 1'b1;
        else if (!(^{shift_q, parity_q})) rx_perr = 1'b1;
        else                            rx_push = 1'b1;
      end
      default: state_d = StIdle;
    endcase
    // Timeout only matters between edges of a partial frame
    if (state_q == StIdle || fall) begin
      tmo_d = '0;
    end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      tmo_d   = '0;
      state_d = StIdle;
      rx_ferr = 1'b1;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  // FIFO bookkeeping, sticky flags, control and registered read data
  always_comb begin
    wr       = sel & |wenable;
    rd       = sel & rd_en;
    empty    = (count_q == '0);
    full     = (count_q == CW'(FIFO_DEPTH));
    pop      = rd & (addr == 4'h0) & ~empty;
    flush    = wr & (addr == 4'h8) & wdata[1];
    push_acc = rx_push & ~flush & (~full | pop);
    ovr_set  = rx_push & ~flush & full & ~pop;
    clr      = wr & (addr == 4'h4);

    // Set wins over a same-cycle write-1-to-clear
    ovr_d    = (ovr_q  & ~(clr & wdata[4])) | ovr_set;
    ferr_d   = (ferr_q & ~(clr & wdata[3])) | rx_ferr;
    perr_d   = (perr_q & ~(clr & wdata[2])) | rx_perr;
    irq_en_d = (wr && addr == 4'h8) ? wdata[0] : irq_en_q;
    irq_d    = irq_en_q & ~empty;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = push_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop      ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q + {{AW{1'b0}}, push_acc} - {{AW{1'b0}}, pop};
    end

    rdata_d = '0;
    if (rd) begin
      case (addr)
        4'h0:    if (!empty) rdata_d = {23'b0, 1'b1, mem_q[rd_ptr_q]};
        4'h4:    rdata_d = {16'b0, 8'(count_q), 3'b0, ovr_q, ferr_q, perr_q, full, empty};
        4'h8:    rdata_d = {31'b0, irq_en_q};
        default: rdata_d = '0;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
      tmo_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
      irq_en_q  <= 1'b0;
      irq_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      parity_q  <= parity_d;
      tmo_q     <= tmo_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovr_q     <= ovr_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
      irq_en_q  <= irq_en_d;
      irq_q     <= irq_d;
      rdata_q   <= rdata_d;
    end
  end

  // Storage array, no reset needed: count gates every read
  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_ptr_q] <= shift_q;
  end

  assign rdata = rdata_q;
  assign irq   = irq_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Self-checking bench for ps2_kbd_ctrl: queue-based model plus literal expectations.
module tb_ps2_kbd_ctrl;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned TMO   = 200;

  logic        clk = 1'b0, rst_n = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic        sel = 1'b0, rd_en = 1'b0;
  logic [3:0]  addr = '0, wenable = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        irq;

  ps2_kbd_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .sel(sel),
    .addr(addr), .wenable(wenable), .wdata(wdata), .rd_en(rd_en), .rdata(rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  // Model state
  byte unsigned mq[$];
  bit          m_ovr = 0, m_ferr = 0, m_perr = 0, m_irq_en = 0;
  logic [31:0] exp_pend = '0;
  bit          chk_on = 0, irq_chk = 0, last_cond = 0;

  function automatic logic [31:0] m_status();
    logic [7:0] cnt;
    cnt = 8'(mq.size());
    return {16'b0, cnt, 3'b0, m_ovr, m_ferr, m_perr, mq.size() == DEPTH, mq.size() == 0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, just after each rising edge
  always @(posedge clk) begin
    #1;
    if (chk_on) begin
      check("rdata_model", rdata, exp_pend);
      if (irq_chk) check("irq_model", {31'b0, irq}, {31'b0, last_cond});
    end
    exp_pend  = '0;
    last_cond = m_irq_en && (mq.size() != 0);
  end

  task automatic bus_rd(input logic [3:0] a);
    @(negedge clk);
    sel = 1; rd_en = 1; addr = a;
    case (a)
      4'h0: begin
        if (mq.size() != 0) begin
          exp_pend = {23'b0, 1'b1, mq[0]};
          void'(mq.pop_front());
        end else exp_pend = '0;
      end
      4'h4:    exp_pend = m_status();
      4'h8:    exp_pend = {31'b0, m_irq_en};
      default: exp_pend = '0;
    endcase
    @(negedge clk);
    sel = 0; rd_en = 0;
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    sel = 1; wenable = 4'h1; addr = a; wdata = d;
    if (a == 4'h4) begin
      if (d[4]) m_ovr = 0;
      if (d[3]) m_ferr = 0;
      if (d[2]) m_perr = 0;
    end else if (a == 4'h8) begin
      m_irq_en = d[0];
      if (d[1]) mq.delete();
    end
    @(negedge clk);
    sel = 0; wenable = 4'h0; wdata = '0;
  endtask

  task automatic rd_lit(input string name, input logic [3:0] a, input logic [31:0] lit);
    bus_rd(a);
    check(name, rdata, lit);
  endtask

  // One PS/2 bit: data set during the high phase, 4-cycle high and low phases
  task automatic ps2_bit(input bit b);
    @(negedge clk) ps2_data = b;
    repeat (4) @(negedge clk);
    ps2_clk = 0;
    repeat (4) @(negedge clk);
    ps2_clk = 1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par_ok, input bit stop);
    irq_chk = 0;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par_ok ? ~^b : ^b);
    ps2_bit(stop);
    @(negedge clk) ps2_data = 1;
    repeat (10) @(negedge clk);
    if (!stop)                    m_ferr = 1;
    else if (!par_ok)             m_perr = 1;
    else if (mq.size() == DEPTH)  m_ovr = 1;
    else                          mq.push_back(b);
    repeat (3) @(negedge clk);
    irq_chk = 1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_rdata", rdata, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    rst_n = 1; chk_on = 1; irq_chk = 1;
    rd_lit("reset_status", 4'h4, 32'h0000_0001);

    // Single frame and empty read
    send_frame(8'h15, 1, 1);
    rd_lit("data_0x15", 4'h0, 32'h0000_0115);
    rd_lit("data_empty", 4'h0, 32'h0000_0000);

    // Two frames with interrupt enabled
    bus_wr(4'h8, 32'h1);
    send_frame(8'h15, 1, 1);
    send_frame(8'h42, 1, 1);
    check("irq_high", {31'b0, irq}, 32'h1);
    rd_lit("status_cnt2", 4'h4, 32'h0000_0200);
    rd_lit("unmapped_rd", 4'hC, 32'h0);
    rd_lit("ctrl_rd", 4'h8, 32'h1);
    rd_lit("data_first", 4'h0, 32'h0000_0115);
    rd_lit("data_second", 4'h0, 32'h0000_0142);
    repeat (2) @(negedge clk);
    check("irq_low", {31'b0, irq}, 32'h0);

    // Parity error, then clear
    send_frame(8'h42, 0, 1);
    rd_lit("status_perr", 4'h4, 32'h0000_0005);
    bus_wr(4'h4, 32'h4);
    rd_lit("status_perr_clr", 4'h4, 32'h0000_0001);

    // Framing error from a zero stop bit
    send_frame(8'h33, 1, 0);
    rd_lit("status_ferr", 4'h4, 32'h0000_0009);
    bus_wr(4'h4, 32'h8);

    // Overflow: one frame more than the FIFO holds
    for (int i = 0; i <= DEPTH; i++) send_frame(8'(i * 17 + 3), 1, 1);
    rd_lit("status_full_ovr", 4'h4, 32'h0000_0812);
    rd_lit("fifo_first", 4'h0, 32'h0000_0103);
    for (int i = 1; i < DEPTH; i++) bus_rd(4'h0);
    rd_lit("status_drained", 4'h4, 32'h0000_0011);
    bus_wr(4'h4, 32'h10);

    // Flush keeps irq_en and reads back as zero
    send_frame(8'hA5, 1, 1);
    send_frame(8'h5A, 1, 1);
    bus_wr(4'h8, 32'h3);
    rd_lit("status_flushed", 4'h4, 32'h0000_0001);
    rd_lit("ctrl_after_flush", 4'h8, 32'h1);
    rd_lit("data_after_flush", 4'h0, 32'h0);

    // Partial frame timeout
    ps2_bit(1'b0);
    ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
    @(negedge clk) ps2_data = 1;
    repeat (TMO + 20) @(negedge clk);
    m_ferr = 1;
    rd_lit("status_timeout", 4'h4, 32'h0000_0009);
    bus_wr(4'h4, 32'h8);
    send_frame(8'h1C, 1, 1);
    rd_lit("data_0x1c", 4'h0, 32'h0000_011C);

    // Reset in the middle of a frame
    irq_chk = 0;
    ps2_bit(1'b0);
    ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
    @(negedge clk) rst_n = 0;
    repeat (3) @(negedge clk);
    mq.delete(); m_ovr = 0; m_ferr = 0; m_perr = 0; m_irq_en = 0;
    rst_n = 1;
    ps2_bit(1'b1);
    repeat (5) @(negedge clk);
    irq_chk = 1;
    send_frame(8'h29, 1, 1);
    rd_lit("data_0x29", 4'h0, 32'h0000_0129);
    rd_lit("status_clean", 4'h4, 32'h0000_0001);
    rd_lit("data_only_one", 4'h0, 32'h0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
